// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent SR flops with a selectable S=R=1 policy, programmable reset value,
// sticky per-channel conflict flags and a saturating conflict-cycle counter.
module sr_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CONF_MODE = 0,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conf_flag,
  output logic [CNT_W-1:0] conf_cnt,
  output logic             conf_any
);

  generate
    if (CONF_MODE < 0 || CONF_MODE > 3 || WIDTH < 1 || CNT_W < 2) begin : g_bad_param
      $error("sr_ff_bank: illegal parameter combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conf_flag_q, conf_flag_d;
  logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;
  logic             conf_any_q, conf_any_d;
  logic [WIDTH-1:0] conf_c;

  always_comb begin
    conf_c = {WIDTH{en & ~clr}} & s & r;
    q_d    = q_q;
    if (clr) begin
      q_d = RST_VAL;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b01: q_d[i] = 1'b0;
          2'b10: q_d[i] = 1'b1;
          2'b11: begin
            case (CONF_MODE)
              1:       q_d[i] = 1'b1;
              2:       q_d[i] = 1'b0;
              3:       q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  // A conflict in the same cycle as clr_err survives the clear.
  always_comb begin
    conf_flag_d = clr_err ? conf_c : (conf_flag_q | conf_c);
    conf_cnt_d  = conf_cnt_q;
    if (clr_err) begin
      conf_cnt_d = {{(CNT_W-1){1'b0}}, |conf_c};
    end else if ((|conf_c) && (conf_cnt_q != CNT_MAX)) begin
      conf_cnt_d = conf_cnt_q + CNT_W'(1);
    end
    conf_any_d = |conf_flag_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q         <= RST_VAL;
      conf_flag_q <= '0;
      conf_cnt_q  <= '0;
      conf_any_q  <= 1'b0;
    end else begin
      q_q         <= q_d;
      conf_flag_q <= conf_flag_d;
      conf_cnt_q  <= conf_cnt_d;
      conf_any_q  <= conf_any_d;
    end
  end

  assign q         = q_q;
  assign qbar      = ~q_q;
  assign conf_flag = conf_flag_q;
  assign conf_cnt  = conf_cnt_q;
  assign conf_any  = conf_any_q;

endmodule
